current_switch_seq: RTL and testbench

- Synchronous controller that drives the `ctrl` thermometer word of the current switch array.
- Accepts target switch counts through a valid/ready handshake and slews `ctrl` one switch at a time, with a programmable dwell per step.
- After the final step it waits a settle interval, then pulses `done`.
- Sits between test/calibration logic and the array, clocked by the emulator clock (`CLK_MSDSL`).

---
 rtl/csw_seq_pkg.sv | 35 +++
 rtl/csw_dwell_cnt.sv | 36 +++
 rtl/current_switch_seq.sv | 149 ++++++++++++++
 tb/tb_current_switch_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csw_seq_pkg.sv
// Shared types and helpers for the current switch sequencer.
//
// Contents:
//   csw_state_t  - controller state (IDLE, SLEW, SETTLE)
//   CSW_MAX_N    - widest switch array the thermometer helper supports
//   therm()      - level -> LSB-aligned thermometer code (CSW_MAX_N bits)
//   clamp_level()- saturate a requested level at the array size
//
// Optional feature macro used by the top: CSW_SEQ_SWEEP_EN.
package csw_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2
  } csw_state_t;

  // Callers cast the result down to their own array width, so this only has
  // to be at least as wide as the largest array instantiated.
  localparam int CSW_MAX_N = 256;

  function automatic logic [CSW_MAX_N-1:0] therm(input int lvl);
    logic [CSW_MAX_N-1:0] t;
    t = '0;
    for (int i = 0; i < CSW_MAX_N; i++) begin
      t[i] = (i < lvl);
    end
    return t;
  endfunction

  function automatic int clamp_level(input int req, input int n_max);
    return (req > n_max) ? n_max : req;
  endfunction

endpackage

// File: rtl/csw_dwell_cnt.sv
// Terminal-count timer used for both the per-step dwell and the settle wait.
//
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  synchronous active-low reset
//   start  in  1  hold/clear the count at zero while high
//   limit  in  W  terminal count value
//   tc     out 1  high while the count equals limit
//
// When not held by start, the count advances every cycle and wraps to zero on
// the cycle after tc, so a limit of L produces a tc every L+1 cycles.
module csw_dwell_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  assign tc = (count == limit);

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      count <= '0;
    end else if (tc) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/current_switch_seq.sv
// Current switch array sequencer: accepts a target switch count over a
// valid/ready handshake, slews the thermometer word one switch per
// STEP_CYCLES, waits SETTLE_CYCLES at the target and then pulses done.
//
// Ports:
//   clk          in  1        clock
//   rst_n        in  1        synchronous active-low reset
//   req_valid    in  1        target request valid
//   req_ready    out 1        controller is idle and can take a request
//   req_target   in  LVL_W    requested number of enabled switches
//   abort        in  1        stop the current move, hold present level
//   sweep_start  in  1        (CSW_SEQ_SWEEP_EN only) full descending sweep
//   ctrl         out N_ARRAY  thermometer code, ones LSB-aligned
//   level        out LVL_W    number of ones in ctrl
//   busy         out 1        not idle
//   done         out 1        one-cycle pulse when a move completes
//   req_clamped  out 1        one-cycle pulse: accepted target exceeded N_ARRAY
//
// Optional feature macro: CSW_SEQ_SWEEP_EN adds sweep_start. N_ARRAY must not
// exceed csw_seq_pkg::CSW_MAX_N.
module current_switch_seq
  import csw_seq_pkg::*;
#(
  parameter int N_ARRAY       = 47,
  parameter int STEP_CYCLES   = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_LEVEL   = 47,
  parameter int LVL_W         = $clog2(N_ARRAY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LVL_W-1:0]   req_target,
  input  logic               abort,
`ifdef CSW_SEQ_SWEEP_EN
  input  logic               sweep_start,
`endif
  output logic [N_ARRAY-1:0] ctrl,
  output logic [LVL_W-1:0]   level,
  output logic               busy,
  output logic               done,
  output logic               req_clamped
);

  localparam int CNT_MAX   = (STEP_CYCLES - 1 > SETTLE_CYCLES) ? STEP_CYCLES - 1 : SETTLE_CYCLES;
  localparam int CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

  localparam logic [CNT_W-1:0] STEP_LIM   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES);
  localparam logic [LVL_W-1:0] N_LVL      = LVL_W'(N_ARRAY);
  localparam logic [LVL_W:0]   N_EXT      = (LVL_W + 1)'(N_ARRAY);
  localparam logic [LVL_W-1:0] RST_LVL    = LVL_W'(RESET_LEVEL);

  csw_state_t       state;
  logic [LVL_W-1:0] tgt;
  logic [LVL_W-1:0] req_tgt;
  logic [LVL_W-1:0] level_step;
  logic             req_over;
  logic             step_start;
  logic             settle_start;
  logic             step_tc;
  logic             settle_tc;

  // Widen by one bit so a target above N_ARRAY can never alias in the compare.
  assign req_over   = ({1'b0, req_target} > N_EXT);
  assign req_tgt    = LVL_W'(clamp_level(int'(req_target), N_ARRAY));
  assign level_step = (tgt > level) ? level + LVL_W'(1) : level - LVL_W'(1);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Each timer is held at zero outside its own state, and abort clears it on
  // the same edge that drops the controller back to IDLE.
  assign step_start   = (state != SLEW) || abort;
  assign settle_start = (state != SETTLE) || abort;

  csw_dwell_cnt #(.W(CNT_W)) u_step_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (step_start),
    .limit (STEP_LIM),
    .tc    (step_tc)
  );

  csw_dwell_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .start (settle_start),
    .limit (SETTLE_LIM),
    .tc    (settle_tc)
  );

  // Controller FSM. ctrl is always written together with level so the
  // thermometer code never lags the level it encodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      level       <= RST_LVL;
      ctrl        <= N_ARRAY'(therm(RESET_LEVEL));
      tgt         <= '0;
      done        <= 1'b0;
      req_clamped <= 1'b0;
    end else begin
      done        <= 1'b0;
      req_clamped <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            tgt         <= req_tgt;
            req_clamped <= req_over;
            state       <= (req_tgt != level) ? SLEW : SETTLE;
          end
`ifdef CSW_SEQ_SWEEP_EN
          else if (sweep_start) begin
            // Jump to all-on, then walk down to zero like a normal move.
            level <= N_LVL;
            ctrl  <= N_ARRAY'(therm(N_ARRAY));
            tgt   <= '0;
            state <= (N_ARRAY != 0) ? SLEW : SETTLE;
          end
`endif
        end
        SLEW: begin
          if (abort) begin
            state <= IDLE;
          end else if (step_tc) begin
            level <= level_step;
            ctrl  <= N_ARRAY'(therm(int'(level_step)));
            if (level_step == tgt) begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state <= IDLE;
          end else if (settle_tc) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_current_switch_seq.sv
// Self-checking bench for current_switch_seq. The reference model predicts
// every observed cycle from elapsed time since the accept edge: the level has
// moved min(distance, k / STEP) switches, done fires at
// distance*STEP + SETTLE + 1, and ctrl is (2**level)-1.
module tb_current_switch_seq;

  localparam int N      = 47;
  localparam int STEP   = 10;
  localparam int SETTLE = 4;
  localparam int RST_LV = 47;
  localparam int LW     = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [LW-1:0] req_target;
  logic          abort;
  logic          sweep_start;
  logic [N-1:0]  ctrl;
  logic [LW-1:0] level;
  logic          busy;
  logic          done;
  logic          req_clamped;

  int total = 0;
  int bad   = 0;
  int model_level;

  always #5 clk = ~clk;

  current_switch_seq #(
    .N_ARRAY       (N),
    .STEP_CYCLES   (STEP),
    .SETTLE_CYCLES (SETTLE),
    .RESET_LEVEL   (RST_LV),
    .LVL_W         (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_target  (req_target),
    .abort       (abort),
`ifdef CSW_SEQ_SWEEP_EN
    .sweep_start (sweep_start),
`endif
    .ctrl        (ctrl),
    .level       (level),
    .busy        (busy),
    .done        (done),
    .req_clamped (req_clamped)
  );

  function automatic logic [N-1:0] exp_ctrl(input int lvl);
    logic [63:0] w;
    w = (64'd1 << lvl) - 64'd1;
    return w[N-1:0];
  endfunction

  // One full move. abort_at >= 0 raises abort after observation k=abort_at.
  task automatic run_move(input int target, input int abort_at, input bit abort_in_idle,
                          input bit sweep);
    int start, tgt, d, dir, done_edge, moved, exp_level, last_k;
    bit over, exp_busy, exp_done;
    start = sweep ? N : model_level;
    over  = sweep ? 1'b0 : (target > N);
    tgt   = sweep ? 0 : (over ? N : target);
    d     = (tgt > start) ? tgt - start : start - tgt;
    dir   = (tgt > start) ? 1 : -1;
    done_edge = d * STEP + SETTLE + 1;
    last_k    = (abort_at >= 0) ? abort_at + 3 : done_edge + 1;
    exp_level = start;

    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ready_idle got=%0b exp=1", req_ready);
    end

    if (sweep) sweep_start = 1'b1;
    else begin
      req_valid  = 1'b1;
      req_target = LW'(target);
    end
    abort = abort_in_idle;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    sweep_start = 1'b0;
    abort       = 1'b0;

    total++;
    if (req_clamped !== over) begin
      bad++;
      $display("[TB] FAIL clamp_pulse tgt=%0d got=%0b exp=%0b", target, req_clamped, over);
    end

    for (int k = 0; k <= last_k; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        total++;
        if (req_clamped !== 1'b0) begin
          bad++;
          $display("[TB] FAIL clamp_width k=%0d got=%0b exp=0", k, req_clamped);
        end
      end
      if (abort_at >= 0 && k > abort_at) begin
        moved    = (abort_at / STEP < d) ? abort_at / STEP : d;
        exp_busy = 1'b0;
        exp_done = 1'b0;
      end else begin
        moved    = (k / STEP < d) ? k / STEP : d;
        exp_busy = (k < done_edge);
        exp_done = (k == done_edge);
      end
      exp_level = start + dir * moved;

      total++;
      if (level !== LW'(exp_level)) begin
        bad++;
        $display("[TB] FAIL level k=%0d got=%0d exp=%0d", k, level, exp_level);
      end
      total++;
      if (ctrl !== exp_ctrl(exp_level)) begin
        bad++;
        $display("[TB] FAIL ctrl k=%0d got=%h exp=%h", k, ctrl, exp_ctrl(exp_level));
      end
      total++;
      if (busy !== exp_busy || req_ready !== !exp_busy) begin
        bad++;
        $display("[TB] FAIL busy k=%0d got=%0b/%0b exp=%0b", k, busy, req_ready, exp_busy);
      end
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("[TB] FAIL done k=%0d got=%0b exp=%0b", k, done, exp_done);
      end

      abort = (abort_at >= 0 && k == abort_at);
    end
    abort = 1'b0;
    model_level = exp_level;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (level !== LW'(RST_LV) || ctrl !== exp_ctrl(RST_LV)) begin
      bad++;
      $display("[TB] FAIL reset_level got=%0d/%h exp=%0d", level, ctrl, RST_LV);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || req_clamped !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%0b%0b%0b%0b exp=1000", req_ready, busy, done,
               req_clamped);
    end
    rst_n = 1'b1;
    model_level = RST_LV;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_down();
    run_move(44, -1, 1'b0, 1'b0);
  endtask

  task automatic test_clamp();
    run_move(63, -1, 1'b0, 1'b0);
  endtask

  task automatic test_same_level();
    run_move(20, -1, 1'b0, 1'b0);
    run_move(20, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_move(15, -1, 1'b0, 1'b0);
    run_move(10, 25, 1'b0, 1'b0);
    run_move(13, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_move();
    req_valid  = 1'b1;
    req_target = LW'(0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++;
    if (level !== LW'(RST_LV) || ctrl !== exp_ctrl(RST_LV) || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset got=%0d busy=%0b exp=%0d busy=0", level, busy, RST_LV);
    end
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (done !== 1'b0 || level !== LW'(RST_LV)) begin
        bad++;
        $display("[TB] FAIL mid_reset_quiet k=%0d done=%0b level=%0d exp=0/%0d", k, done, level,
                 RST_LV);
      end
    end
    model_level = RST_LV;
  endtask

  task automatic test_random_moves();
    int t, de, ab;
    for (int i = 0; i < 10; i++) begin
      t  = $urandom_range(0, 63);
      de = (t > N ? N : t);
      de = ((de > model_level) ? de - model_level : model_level - de) * STEP + SETTLE + 1;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, de - 1) : -1;
      run_move(t, ab, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

`ifdef CSW_SEQ_SWEEP_EN
  task automatic test_sweep();
    run_move(0, -1, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_target  = '0;
    abort       = 1'b0;
    sweep_start = 1'b0;
    model_level = RST_LV;

    test_reset();
    test_basic_down();
    test_clamp();
    test_same_level();
    test_abort();
    test_reset_mid_move();
    test_random_moves();
`ifdef CSW_SEQ_SWEEP_EN
    test_sweep();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
